// File: rtl/crg_dout_unpack.sv
// crg_dout_unpack: rebuilds 784-bit {a, b, c, e, pad} words from a stream of
// 112-bit beats. Each finished word goes into a small FIFO that drives a
// valid/ready output port. Overflow and pad errors are reported with sticky
// flags, and a counter tracks how many frames were pushed.
module crg_dout_unpack #(
  parameter int PRNG_W     = 256,
  parameter int BEAT_W     = 112,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              beat_vld_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              resync_i,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic [PRNG_W-1:0] a_o,
  output logic [PRNG_W-1:0] b_o,
  output logic [PRNG_W-1:0] c_o,
  output logic [7:0]        e_o,
  output logic              ovf_o,
  output logic              pad_err_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int WORD_W  = 3 * PRNG_W + 16;     // {a, b, c, e, 8'h00}
  localparam int ENTRY_W = 3 * PRNG_W + 8;      // {a, b, c, e}; pad is dropped
  localparam int NBEATS  = WORD_W / BEAT_W;
  localparam int IDX_W   = $clog2(NBEATS);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  asm_q, asm_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic               pad_err_q, pad_err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               accept;
  logic               frame_done;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  // A resync discards the beat presented in the same cycle.
  assign accept     = beat_vld_i && !resync_i;
  assign frame_done = accept && (idx_q == LAST_IDX);

  // The pointers carry one extra wrap bit. When the index bits match, this bit
  // tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && rdy_i;

  // If a pop happens in the same cycle, it frees a slot, so a full FIFO can
  // still accept the new frame.
  assign push  = frame_done && (!full || pop);
  assign drop  = frame_done && full && !pop;

  // Overlay the incoming beat onto its slot of the assembly word.
  always_comb begin
    // NOTE: give every combinational output a default first, so that no path
    // leaves it unassigned and infers a latch.
    asm_d = asm_q;
    for (int k = 0; k < NBEATS; k++) begin
      if (accept && (idx_q == IDX_W'(k))) begin
        asm_d[k*BEAT_W +: BEAT_W] = beat_i;
      end
    end
  end

  // Next state for the beat index, FIFO pointers, sticky flags and frame count.
  always_comb begin
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    ovf_d       = ovf_q | drop;
    pad_err_d   = pad_err_q | (accept && (idx_q == '0) && (beat_i[7:0] != 8'h00));
    frame_cnt_d = frame_cnt_q + 16'(push);
    if (resync_i) begin
      idx_d = '0;
    end else if (beat_vld_i) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Control state register with synchronous reset; reset overrides all inputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // register-to-register updates free of simulation race conditions.
    if (rst_i) begin
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      pad_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      pad_err_q   <= pad_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Datapath storage: the assembly word and the FIFO entries.
  always_ff @(posedge clk_i) begin
    // NOTE: the data arrays have no reset. Their content is meaningless until
    // it is written, and the reset pointers already mark the FIFO empty.
    asm_q <= asm_d;
    if (push && !rst_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= asm_d[WORD_W-1 -: ENTRY_W];
    end
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign vld_o       = !empty;
  assign a_o         = head[ENTRY_W-1 -: PRNG_W];
  assign b_o         = head[ENTRY_W-PRNG_W-1 -: PRNG_W];
  assign c_o         = head[ENTRY_W-2*PRNG_W-1 -: PRNG_W];
  assign e_o         = head[7:0];
  assign ovf_o       = ovf_q;
  assign pad_err_o   = pad_err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_crg_dout_unpack.sv
// Self-checking bench for crg_dout_unpack. Each expected word is queued when
// its frame is driven, and popped and compared when the DUT hands it off.
module tb_crg_dout_unpack;

  localparam int PRNG_W  = 256;
  localparam int BEAT_W  = 112;
  localparam int WORD_W  = 784;
  localparam int ENTRY_W = 776;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  typedef struct {
    logic [PRNG_W-1:0] a;
    logic [PRNG_W-1:0] b;
    logic [PRNG_W-1:0] c;
    logic [7:0]        e;
    logic [7:0]        pad;
    int                gap;
    logic              exp_pad_err;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              beat_vld_i;
  logic [BEAT_W-1:0] beat_i;
  logic              resync_i;
  logic              vld_o;
  logic              rdy_i;
  logic [PRNG_W-1:0] a_o, b_o, c_o;
  logic [7:0]        e_o;
  logic              ovf_o;
  logic              pad_err_o;
  logic [15:0]       frame_cnt_o;

  int     n_pass  = 0;
  int     n_total = 0;
  int     exp_cnt = 0;
  entry_t sb_q[$];
  entry_t sb_head;
  vec_t   vecs[5];
  word_t  w1, w2, w3, wx, wy;

  crg_dout_unpack #(
    .PRNG_W(PRNG_W), .BEAT_W(BEAT_W), .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .beat_vld_i(beat_vld_i), .beat_i(beat_i), .resync_i(resync_i),
    .vld_o(vld_o), .rdy_i(rdy_i),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .e_o(e_o),
    .ovf_o(ovf_o), .pad_err_o(pad_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input entry_t act, input entry_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic word_t mk_word(input logic [PRNG_W-1:0] a, b, c,
                                    input logic [7:0] e, pad);
    return {a, b, c, e, pad};
  endfunction

  function automatic entry_t to_entry(input word_t w);
    return w[WORD_W-1:8];
  endfunction

  // Drive beats first..last of a word, with gap idle cycles between beats.
  task automatic send_beats(input word_t w, input int first, input int last,
                            input int gap, input bit watch_vld);
    for (int k = first; k <= last; k++) begin
      beat_vld_i = 1'b1;
      beat_i     = w[k*BEAT_W +: BEAT_W];
      @(posedge clk_i); #1;
      beat_vld_i = 1'b0;
      beat_i     = '0;
      if (k < last) begin
        if (watch_vld) check("no_early_vld", vld_o, 0);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk_i); #1;
          if (watch_vld) check("no_early_vld_gap", vld_o, 0);
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check("drain_done", entry_t'(sb_q.size()), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; beat_vld_i = 1'b0; beat_i = '0; resync_i = 1'b0; rdy_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb_q.delete();
    exp_cnt = 0;
  endtask

  // Scoreboard monitor: a handshake seen at negedge pops at the next posedge.
  always @(negedge clk_i) begin
    if (!rst_i && vld_o && rdy_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", entry_t'(vld_o), 0);
      end else begin
        sb_head = sb_q.pop_front();
        check("pop_data", {a_o, b_o, c_o, e_o}, sb_head);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{{32{8'h11}}, {32{8'h22}}, {32{8'h33}}, 8'hA5, 8'h00, 0, 1'b0};
    vecs[1] = '{{32{8'h11}}, {32{8'h22}}, {32{8'h33}}, 8'hA5, 8'h00, 3, 1'b0};
    vecs[2] = '{{8{32'hDEADBEEF}}, {8{32'h01234567}}, {8{32'hFEDCBA98}},
                8'h3C, 8'h00, 1, 1'b0};
    vecs[3] = '{{256{1'b1}}, {256{1'b0}}, {64{4'hA}}, 8'h01, 8'h01, 0, 1'b1};
    vecs[4] = '{{32{8'h11}}, {32{8'h22}}, {32{8'h33}}, 8'hA5, 8'h00, 2, 1'b1};

    do_reset();
    check("rst_vld", vld_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_pad", pad_err_o, 0);
    check("rst_cnt", frame_cnt_o, 0);

    // Table: single, gapped, patterned and pad-error frames with rdy_i=1.
    for (int i = 0; i < 5; i++) begin
      w1 = mk_word(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, vecs[i].pad);
      sb_q.push_back(to_entry(w1));
      send_beats(w1, 0, 6, vecs[i].gap, 1'b1);
      check("latency_vld", vld_o, 1);
      wait_drain();
      exp_cnt++;
      check("frame_cnt", frame_cnt_o, entry_t'(16'(exp_cnt)));
      check("pad_err", pad_err_o, vecs[i].exp_pad_err);
      check("ovf_clear", ovf_o, 0);
    end

    // Backpressure: three frames into a two-deep FIFO with rdy_i low.
    w1 = mk_word({64{4'h1}}, {64{4'h2}}, {64{4'h3}}, 8'h01, 8'h00);
    w2 = mk_word({64{4'h4}}, {64{4'h5}}, {64{4'h6}}, 8'h02, 8'h00);
    w3 = mk_word({64{4'h7}}, {64{4'h8}}, {64{4'h9}}, 8'h03, 8'h00);
    rdy_i = 1'b0;
    sb_q.push_back(to_entry(w1));
    send_beats(w1, 0, 6, 0, 1'b0);
    sb_q.push_back(to_entry(w2));
    send_beats(w2, 0, 6, 0, 1'b0);
    check("bp_no_ovf_yet", ovf_o, 0);
    send_beats(w3, 0, 6, 0, 1'b0);
    exp_cnt += 2;
    check("bp_ovf", ovf_o, 1);
    check("bp_cnt", frame_cnt_o, entry_t'(16'(exp_cnt)));
    check("bp_head", {a_o, b_o, c_o, e_o}, to_entry(w1));
    repeat (3) @(posedge clk_i);
    #1;
    check("bp_hold_vld", vld_o, 1);
    check("bp_hold_head", {a_o, b_o, c_o, e_o}, to_entry(w1));
    rdy_i = 1'b1;
    wait_drain();
    check("bp_empty", vld_o, 0);
    check("bp_ovf_sticky", ovf_o, 1);

    // Reset after three beats, with a beat also presented in the reset cycle.
    send_beats(w1, 0, 2, 0, 1'b0);
    rst_i = 1'b1; beat_vld_i = 1'b1; beat_i = w1[3*BEAT_W +: BEAT_W];
    @(posedge clk_i); #1;
    beat_vld_i = 1'b0;
    check("mid_rst_vld", vld_o, 0);
    check("mid_rst_ovf", ovf_o, 0);
    check("mid_rst_pad", pad_err_o, 0);
    check("mid_rst_cnt", frame_cnt_o, 0);
    rst_i = 1'b0;
    exp_cnt = 0;
    sb_q.push_back(to_entry(w2));
    send_beats(w2, 0, 6, 0, 1'b1);
    check("post_rst_vld", vld_o, 1);
    wait_drain();
    exp_cnt++;
    check("post_rst_cnt", frame_cnt_o, entry_t'(16'(exp_cnt)));

    // FIFO full, and a pop lands in the same cycle as the third push.
    rdy_i = 1'b0;
    sb_q.push_back(to_entry(w1));
    send_beats(w1, 0, 6, 0, 1'b0);
    sb_q.push_back(to_entry(w2));
    send_beats(w2, 0, 6, 0, 1'b0);
    send_beats(w3, 0, 5, 0, 1'b0);
    rdy_i = 1'b1;
    sb_q.push_back(to_entry(w3));
    send_beats(w3, 6, 6, 0, 1'b0);
    check("fullpop_ovf", ovf_o, 0);
    wait_drain();
    exp_cnt += 3;
    check("fullpop_cnt", frame_cnt_o, entry_t'(16'(exp_cnt)));
    check("fullpop_ovf_end", ovf_o, 0);

    // Resync after four beats. The beat presented with resync_i is discarded,
    // so its nonzero low byte must not set pad_err_o.
    wx = mk_word({32{8'hEE}}, {32{8'hDD}}, {32{8'hCC}}, 8'h77, 8'h00);
    wy = mk_word({16{16'hC0DE}}, {16{16'hBEEF}}, {16{16'hF00D}}, 8'h9A, 8'h00);
    send_beats(wx, 0, 3, 0, 1'b1);
    resync_i = 1'b1; beat_vld_i = 1'b1; beat_i = 112'hFF;
    @(posedge clk_i); #1;
    resync_i = 1'b0; beat_vld_i = 1'b0; beat_i = '0;
    check("resync_no_vld", vld_o, 0);
    check("resync_cnt_kept", frame_cnt_o, entry_t'(16'(exp_cnt)));
    sb_q.push_back(to_entry(wy));
    send_beats(wy, 0, 6, 0, 1'b1);
    check("resync_vld", vld_o, 1);
    wait_drain();
    exp_cnt++;
    check("resync_cnt", frame_cnt_o, entry_t'(16'(exp_cnt)));
    check("resync_pad", pad_err_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("resync_idle", vld_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crg_dout_unpack.md
CRG_DOUT_UNPACK -- requirements
Module: crg_dout_unpack

Interface
REQ-001 SHALL have parameter PRNG_W, default 256, width of each of the a/b/c shares.
REQ-002 SHALL have parameter BEAT_W, default 112, width of one input beat.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of reassembled words held (power of two, at least 2).
REQ-004 SHALL have one clock and synchronous active-high reset: clk_i input 1 (sole clock, all logic on posedge); rst_i input 1 (synchronous, active-high).
REQ-005 SHALL have ports:
- beat_vld_i input 1: one beat present this cycle.
- beat_i input BEAT_W: beat data.
- resync_i input 1: discard the partial frame and realign to beat 0.
- vld_o output 1: head word valid.
- rdy_i input 1: consumer accepts the head word.
- a_o, b_o, c_o output PRNG_W each: reassembled shares.
- e_o output 8: reassembled e value.
- ovf_o output 1: sticky overflow flag.
- pad_err_o output 1: sticky pad-error flag.
- frame_cnt_o output 16: frames pushed.

Function
REQ-006 SHALL define a frame as 7 beats forming word W[783:0] = {a, b, c, e, 8'h00}; beat k (k=0..6) carries W[112k+111:112k]; beat 0 arrives first.
REQ-007 SHALL keep a 3-bit beat index: increment on each accepted beat; wrap 6->0; values 7 never reached.
REQ-008 SHALL store each beat into its slot of a 784-bit assembly register in the cycle it is accepted.
REQ-009 SHALL complete the frame on the cycle beat 6 is accepted, and push {a,b,c,e} into the FIFO on the next clock edge; beat 6 to vld_o high takes 1 cycle when the FIFO was empty.
REQ-010 SHALL set pad_err_o when beat 0 has bits [7:0] != 8'h00; the frame is still pushed.
REQ-011 SHALL drop a completed frame if the FIFO is full and no pop occurs in the same cycle, set ovf_o, and leave FIFO contents unchanged.
REQ-012 SHALL allow a simultaneous push and pop when full; the result is a legal push with no overflow.
REQ-013 SHALL pop on vld_o && rdy_i; a_o/b_o/c_o/e_o always show the head entry, and are don't-care while vld_o=0.
REQ-014 SHALL keep vld_o and the head data stable while vld_o=1 and rdy_i=0.
REQ-015 SHALL, on resync_i=1, zero the beat index and discard the beat presented that cycle; FIFO contents, flags and frame_cnt_o are unchanged.
REQ-016 SHALL increment frame_cnt_o on each successful push; wrap 16'hFFFF->0; dropped frames are not counted.
REQ-017 SHALL keep ovf_o and pad_err_o set until reset.

Reset
REQ-018 SHALL, on rst_i=1 at a clock edge, drive vld_o=0, ovf_o=0, pad_err_o=0, frame_cnt_o=0, set beat index to 0, and empty the FIFO; the assembly register content is don't-care.
REQ-019 SHALL let reset override all other inputs in the same cycle; a reset mid-frame discards the partial frame.

Verification
REQ-020 Single frame: 7 consecutive beats encoding a=0x11..11, b=0x22..22, c=0x33..33, e=0xA5, rdy_i=1 -> vld_o high 1 cycle after beat 6 with exact a/b/c/e; frame_cnt_o=1.
REQ-021 Gapped beats: same frame with beat_vld_i low 3 cycles between each beat -> identical output; no early vld_o.
REQ-022 Backpressure: rdy_i=0, 3 frames sent -> 2 held, ovf_o=1, frame_cnt_o=2; then rdy_i=1 -> frames 1 and 2 emitted in order.
REQ-023 Full with pop on completion: FIFO full, rdy_i=1 in the cycle frame 3 pushes -> ovf_o=0, 3 frames emitted in order.
REQ-024 Resync/reset: 4 beats, then resync_i, then a full frame -> only the new frame is emitted; reset after 3 beats -> all outputs at reset values, and the next 7 beats form a correct frame.
REQ-025 Pad error: beat 0 with bits [7:0]=0x01 -> pad_err_o=1 sticky, frame still emitted.
